// File: rtl/pwm_dt_pkg.sv
// Shared types and default widths for the PWM dead-time stage.
package pwm_dt_pkg;

  localparam int unsigned CHNL_NUM_DEF = 4;
  localparam int unsigned DT_WIDTH_DEF = 8;

  typedef enum logic [2:0] {
    ST_OFF     = 3'd0,
    ST_LOW     = 3'd1,
    ST_DT_RISE = 3'd2,
    ST_HIGH    = 3'd3,
    ST_DT_FALL = 3'd4
  } dt_state_e;

  // True while a channel sits in either dead-time window.
  function automatic logic is_dt_state(input dt_state_e s);
    return (s == ST_DT_RISE) || (s == ST_DT_FALL);
  endfunction

endpackage

// File: rtl/pwm_dt_chnl.sv
// One channel: complementary H/L FSM with a programmable dead-time down-counter.
module pwm_dt_chnl
  import pwm_dt_pkg::*;
#(
  parameter int unsigned DT_WIDTH = DT_WIDTH_DEF
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                force_off_i,
  input  logic                pwm_i,
  input  logic [DT_WIDTH-1:0] dt_rise_i,
  input  logic [DT_WIDTH-1:0] dt_fall_i,
  output logic                pwm_h_o,
  output logic                pwm_l_o,
  output logic                dt_active_o
);

  dt_state_e           state_q, state_d;
  logic [DT_WIDTH-1:0] cnt_q, cnt_d;
  logic                from_high_q, from_high_d;
  logic                h_q, h_d;
  logic                l_q, l_d;
  logic                dta_q, dta_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_OFF;
      cnt_q       <= '0;
      from_high_q <= 1'b0;
      h_q         <= 1'b0;
      l_q         <= 1'b0;
      dta_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      from_high_q <= from_high_d;
      h_q         <= h_d;
      l_q         <= l_d;
      dta_q       <= dta_d;
    end
  end

  // Next state; a zero dead time switches H/L directly in a single edge.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    from_high_d = from_high_q;
    case (state_q)
      ST_OFF: begin
        state_d     = ST_DT_FALL;
        cnt_d       = dt_fall_i;
        from_high_d = 1'b0;
      end
      ST_LOW: begin
        if (pwm_i) begin
          if (dt_rise_i == '0) begin
            state_d = ST_HIGH;
            cnt_d   = '0;
          end else begin
            state_d = ST_DT_RISE;
            cnt_d   = dt_rise_i;
          end
        end
      end
      ST_DT_RISE: begin
        if (!pwm_i) begin
          state_d = ST_LOW;
          cnt_d   = '0;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - DT_WIDTH'(1);
        end else begin
          state_d = ST_HIGH;
        end
      end
      ST_HIGH: begin
        if (!pwm_i) begin
          if (dt_fall_i == '0) begin
            state_d = ST_LOW;
            cnt_d   = '0;
          end else begin
            state_d     = ST_DT_FALL;
            cnt_d       = dt_fall_i;
            from_high_d = 1'b1;
          end
        end
      end
      ST_DT_FALL: begin
        // Returning to HIGH is only safe when L was never driven since HIGH.
        if (pwm_i && from_high_q) begin
          state_d = ST_HIGH;
          cnt_d   = '0;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - DT_WIDTH'(1);
        end else begin
          state_d = ST_LOW;
        end
      end
      default: begin
        state_d = ST_OFF;
        cnt_d   = '0;
      end
    endcase
    if (force_off_i) begin
      state_d     = ST_OFF;
      cnt_d       = '0;
      from_high_d = 1'b0;
    end
    h_d   = (state_d == ST_HIGH);
    l_d   = (state_d == ST_LOW);
    dta_d = is_dt_state(state_d);
  end

  assign pwm_h_o     = h_q;
  assign pwm_l_o     = l_q;
  assign dt_active_o = dta_q;

  a_no_overlap: assert property (@(posedge clk_i) !(h_q && l_q));
  a_dt_flag:    assert property (@(posedge clk_i) dta_q == is_dt_state(state_q));

endmodule

// File: rtl/pwm_deadtime.sv
// Complementary dead-time stage for CHNL_NUM PWM channels.
// Optional brake/fault path enabled by defining PWM_DT_BRAKE_EN.
module pwm_deadtime
  import pwm_dt_pkg::*;
#(
  parameter int unsigned CHNL_NUM = CHNL_NUM_DEF,
  parameter int unsigned DT_WIDTH = DT_WIDTH_DEF
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                en_i,
  input  logic [DT_WIDTH-1:0] dt_rise_i,
  input  logic [DT_WIDTH-1:0] dt_fall_i,
  input  logic [CHNL_NUM-1:0] pwm_i,
`ifdef PWM_DT_BRAKE_EN
  input  logic                brake_i,
  input  logic                brake_clr_i,
  output logic                fault_o,
`endif
  output logic [CHNL_NUM-1:0] pwm_h_o,
  output logic [CHNL_NUM-1:0] pwm_l_o,
  output logic [CHNL_NUM-1:0] dt_active_o
);

  logic force_off;

`ifdef PWM_DT_BRAKE_EN
  logic fault_q, fault_d;

  // Sticky fault: brake sets it and wins over a simultaneous clear.
  always_comb begin
    fault_d = fault_q;
    if (brake_i) begin
      fault_d = 1'b1;
    end else if (brake_clr_i) begin
      fault_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fault_q <= 1'b0;
    end else begin
      fault_q <= fault_d;
    end
  end

  assign fault_o   = fault_q;
  assign force_off = !en_i || brake_i || fault_q;
`else
  assign force_off = !en_i;
`endif

  for (genvar g = 0; g < int'(CHNL_NUM); g++) begin : g_chnl
    pwm_dt_chnl #(
      .DT_WIDTH (DT_WIDTH)
    ) u_chnl (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .force_off_i (force_off),
      .pwm_i       (pwm_i[g]),
      .dt_rise_i   (dt_rise_i),
      .dt_fall_i   (dt_fall_i),
      .pwm_h_o     (pwm_h_o[g]),
      .pwm_l_o     (pwm_l_o[g]),
      .dt_active_o (dt_active_o[g])
    );
  end

endmodule
